// File: rtl/serial_receiver_if.sv
// Bundle of the receiver's line, configuration and RX FIFO write-side signals.
// data/parity_error/framing_error are meaningful only in the clk where data_write is high.
interface serial_receiver_if;
  logic       brgen;
  logic       enable;
  logic [1:0] size;
  logic       stop2;
  logic [1:0] parity;
  logic       full;
  logic       in;
  logic [8:0] data;
  logic       data_write;
  logic       parity_error;
  logic       framing_error;
  logic       overrun;

  // Write-side handshake: data_write is a one-clk valid strobe with no ready;
  // full is the FIFO's back-pressure, looked at only when a frame completes,
  // and a completed frame that meets full==1 is dropped and reported by overrun.
  modport master (
    output brgen, enable, size, stop2, parity, full, in,
    input  data, data_write, parity_error, framing_error, overrun
  );

  modport slave (
    input  brgen, enable, size, stop2, parity, full, in,
    output data, data_write, parity_error, framing_error, overrun
  );
endinterface

// File: rtl/serial_receiver.sv
// UART receive stage: 16x oversampled deserialiser for 5-8 data bits, optional
// parity and 1-2 stop bits, writing each completed frame with its status flags.
module serial_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  serial_receiver_if.slave    rx,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  state_e     state_q;
  logic [3:0] tick_q;
  logic [2:0] bit_q;
  logic [8:0] shift_q;
  logic       par_err_q;
  logic       fe_q;
  logic       armed_q;
  logic [8:0] data_q;
  logic       data_write_q;
  logic       parity_error_q;
  logic       framing_error_q;
  logic       overrun_q;

  logic rin;
  logic tick_d;
  logic sample_d;
  logic complete_d;
  logic fe_final_d;
  logic frame_xor_d;

  assign rin         = sync_q[SYNC_STAGES-1];
  assign tick_d      = rx.brgen & rx.enable;
  assign sample_d    = tick_d & (tick_q == LAST_TICK);
  assign complete_d  = sample_d & (((state_q == STOP1) & ~rx.stop2) | (state_q == STOP2));
  assign fe_final_d  = ((state_q == STOP2) & fe_q) | ~rin;
  assign frame_xor_d = (^shift_q[7:0]) ^ rin;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx.in};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= IDLE;
      tick_q          <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      par_err_q       <= 1'b0;
      fe_q            <= 1'b0;
      armed_q         <= 1'b1;
      data_q          <= '0;
      data_write_q    <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      data_write_q <= 1'b0;
      overrun_q    <= 1'b0;
      if (!rx.enable) begin
        state_q <= IDLE;
        tick_q  <= '0;
        bit_q   <= '0;
        armed_q <= 1'b0;
      end else if (rx.brgen) begin
        case (state_q)
          // After a frame ending on a low line (break), wait for a high sample first.
          IDLE: begin
            tick_q <= '0;
            if (!armed_q) armed_q <= rin;
            else if (!rin) state_q <= START;
          end
          START: begin
            if (tick_q == MID_TICK) begin
              tick_q    <= '0;
              bit_q     <= '0;
              shift_q   <= '0;
              par_err_q <= 1'b0;
              state_q   <= rin ? IDLE : DATA;
            end else begin
              tick_q <= tick_q + 4'd1;
            end
          end
          DATA: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == LAST_TICK) begin
              shift_q[bit_q] <= rin;
              bit_q          <= bit_q + 3'd1;
              if (bit_q == {1'b1, rx.size})
                state_q <= (rx.parity != 2'b00) ? PARITY : STOP1;
            end
          end
          PARITY: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == LAST_TICK) begin
              case (rx.parity)
                2'b01:   par_err_q  <= frame_xor_d;
                2'b10:   par_err_q  <= ~frame_xor_d;
                2'b11:   shift_q[8] <= rin;
                default: par_err_q  <= 1'b0;
              endcase
              state_q <= STOP1;
            end
          end
          STOP1: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == LAST_TICK) begin
              fe_q    <= ~rin;
              state_q <= rx.stop2 ? STOP2 : IDLE;
            end
          end
          STOP2: begin
            tick_q <= tick_q + 4'd1;
            if (tick_q == LAST_TICK) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase

        if (complete_d) begin
          data_q          <= shift_q;
          parity_error_q  <= par_err_q;
          framing_error_q <= fe_final_d;
          armed_q         <= rin;
          if (rx.full) overrun_q    <= 1'b1;
          else         data_write_q <= 1'b1;
        end
      end
    end
  end

  assign rx.data          = data_q;
  assign rx.data_write    = data_write_q;
  assign rx.parity_error  = parity_error_q;
  assign rx.framing_error = framing_error_q;
  assign rx.overrun       = overrun_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_serial_receiver.sv
// Bench for serial_receiver: frames are driven bit by bit on the line, the expected
// outcome of each frame is queued at issue time and checked by an independent monitor.
module tb_serial_receiver;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] state_dbg;
  int         tests = 0;
  int         fails = 0;
  int         cycle = 0;
  int         last_evt_cycle = 0;
  int         bcnt = 0;

  // {overrun, parity_error, framing_error, data[8:0]}
  logic [11:0] exp_q[$];

  serial_receiver_if rx();

  serial_receiver #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset / baud tick ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    bcnt     = (bcnt + 1) % 4;
    rx.brgen = (bcnt == 0);
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] model(input logic [7:0] d, input int nbits, input logic [1:0] pm,
                                        input logic pb, input logic s1, input logic s2,
                                        input logic two, input logic fl);
    logic [8:0] v;
    int         ones;
    logic       pe;
    logic       fe;
    v    = 9'(int'(d) % (1 << nbits));
    ones = $countones(v[7:0]) + int'(pb);
    if (pm == 2'b11) v[8] = pb;
    if (pm == 2'b01)      pe = (ones % 2 == 1);
    else if (pm == 2'b10) pe = (ones % 2 == 0);
    else                  pe = 1'b0;
    fe = !s1 || (two && !s2);
    return {fl, pe, fe, v};
  endfunction

  function automatic logic good_parity(input logic [7:0] d, input int nbits, input logic [1:0] pm);
    logic [7:0] dm;
    dm = 8'(int'(d) % (1 << nbits));
    return (pm == 2'b10) ? ~(^dm) : ^dm;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rx.data_write || rx.overrun) begin
      last_evt_cycle = cycle;
      if (exp_q.size() == 0) begin
        check("unexpected_output", {20'd0, rx.overrun, rx.parity_error, rx.framing_error, rx.data}, 32'hFFFF_FFFF);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if (e[11])
          check("overrun_event", {30'd0, rx.data_write, rx.overrun}, 32'd1);
        else
          check("frame_write", {19'd0, rx.data_write, rx.overrun, rx.parity_error, rx.framing_error, rx.data},
                {19'd0, 1'b1, 1'b0, e[10:0]});
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (!rx.brgen) @(posedge clk);
    end
  endtask

  task automatic hold(input logic v, input int n);
    @(negedge clk);
    rx.in = v;
    wait_ticks(n);
  endtask

  task automatic send(input logic [7:0] d, input int nbits, input logic [1:0] pm, input logic pb,
                      input logic s1, input logic s2, input logic two);
    hold(1'b0, 16);
    for (int i = 0; i < nbits; i++) hold(d[i], 16);
    if (pm != 2'b00) hold(pb, 16);
    hold(s1, 16);
    if (two) hold(s2, 16);
    hold(1'b1, 8);
  endtask

  task automatic frame(input logic [7:0] d, input int nbits, input logic [1:0] pm, input logic pb,
                       input logic s1, input logic s2, input logic two, input logic fl);
    @(negedge clk);
    rx.size   = 2'(nbits - 5);
    rx.parity = pm;
    rx.stop2  = two;
    rx.full   = fl;
    exp_q.push_back(model(d, nbits, pm, pb, s1, s2, two, fl));
    send(d, nbits, pm, pb, s1, s2, two);
    @(negedge clk);
    rx.full = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         t0;
    int         lat;
    int         nb;
    logic [7:0] d;
    logic [1:0] pm;
    logic       pb;
    logic       two;
    logic       s1;
    logic       s2;
    logic       fl;

    rx.enable = 1'b1;
    rx.in     = 1'b1;
    rx.full   = 1'b0;
    rx.size   = 2'b11;
    rx.parity = 2'b00;
    rx.stop2  = 1'b0;
    reset     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {19'd0, rx.data, rx.data_write, rx.parity_error, rx.framing_error, rx.overrun}, 32'd0);
    reset = 1'b1;
    hold(1'b1, 4);

    // 8N1 0xA5 with completion latency of ~9.5 bit times (152 ticks * 4 clks)
    t0 = cycle;
    frame(8'hA5, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    lat = last_evt_cycle - t0;
    check("a5_latency_in_window", 32'(lat >= 600 && lat <= 630), 32'd1);

    // 7E1 0x41, correct then flipped parity bit
    frame(8'h41, 7, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    frame(8'h41, 7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // false start: short low glitch, then a good frame
    rx.size = 2'b11; rx.parity = 2'b00; rx.stop2 = 1'b0;
    hold(1'b0, 5);
    hold(1'b1, 20);
    frame(8'h3C, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // framing error, then 5-bit raw 9th bit with two stop bits
    frame(8'hFF, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    frame(8'h15, 5, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // overrun then a normal write
    frame(8'h55, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    frame(8'hAA, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // reset pulse during data bit 2; remaining bits of 0xFE keep the line high
    @(negedge clk);
    rx.size = 2'b11; rx.parity = 2'b00; rx.stop2 = 1'b0;
    fork
      send(8'hFE, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        wait_ticks(56);
        @(negedge clk); reset = 1'b0;
        @(negedge clk); reset = 1'b1;
      end
    join
    frame(8'h99, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // enable dropped during data bit 2
    fork
      send(8'hFE, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        wait_ticks(56);
        @(negedge clk); rx.enable = 1'b0;
        wait_ticks(10);
        @(negedge clk); rx.enable = 1'b1;
      end
    join
    frame(8'h99, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // break: exactly one all-zero frame with framing error while line stays low
    exp_q.push_back(model(8'h00, 8, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    hold(1'b0, 16 * 14);
    hold(1'b1, 20);
    frame(8'h5A, 8, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // randomized frames
    for (int k = 0; k < 16; k++) begin
      nb  = $urandom_range(5, 8);
      d   = 8'($urandom_range(0, 255));
      pm  = 2'($urandom_range(0, 3));
      two = 1'($urandom_range(0, 1));
      if (pm == 2'b11)      pb = 1'($urandom_range(0, 1));
      else if (pm == 2'b00) pb = 1'b0;
      else begin
        pb = good_parity(d, nb, pm);
        if ($urandom_range(0, 3) == 0) pb = ~pb;
      end
      s1 = ($urandom_range(0, 5) != 0);
      s2 = ($urandom_range(0, 5) != 0);
      fl = ($urandom_range(0, 4) == 0);
      frame(d, nb, pm, pb, s1, s2, two, fl);
    end

    for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("expected_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
